mp_add_seq: RTL and testbench
=============================

# mp_add_seq

Sequential multi-precision adder/subtractor. It streams operands as 16-bit limbs, least-significant first, through a single `cla_16bit` instance and chains the carry between limbs in a register, so one small adder serves arbitrarily wide words. It sits between the operand source and the result consumer, with valid/ready handshakes on both sides. It is the stage that feeds `cla_16bit` and consumes its `sum` and `cout`.

## Interface
Parameters:
- `WORDS`, default 4: limbs per operand; must be ≥ 2 (4 gives 64-bit operands).

Ports (clock and reset first):
- `clk` — in, 1: single clock; all state updates on the rising edge.
- `rst` — in, 1: reset, asynchronous, active-high.
- `in_valid` — in, 1: limb presented.
- `in_ready` — out, 1: limb accepted when `in_valid && in_ready`.
- `in_a` — in, 16: limb of operand A.
- `in_b` — in, 16: limb of operand B.
- `in_first` — in, 1: limb is the least-significant limb of a new operand.
- `in_cin` — in, 1: carry-in; used on the first limb only.
- `in_sub` — in, 1: subtract (A−B); sampled on the first limb and held for the whole operand.
- `out_valid` — out, 1: result limb present.
- `out_ready` — in, 1: consumer takes the limb when `out_valid && out_ready`.
- `out_sum` — out, 16: result limb.
- `out_last` — out, 1: limb is the most-significant limb.
- `out_cout` — out, 1: final carry-out; meaningful only when `out_last` is 1, otherwise 0.
- `out_ovf` — out, 1: signed overflow of the full-width result; meaningful only when `out_last` is 1, otherwise 0.
- `err` — out, 1: sticky protocol error flag; cleared only by `rst`.

## Operation
- State registers:
  - `cnt` — limb index, 0..WORDS-1.
  - `carry_q` — carry between limbs.
  - `sub_q` — subtract mode held for the operand.
  - One output register set.
- Adder inputs:
  - a = `in_a`.
  - b = `in_b` ^ {16{s}}, where s = first ? `in_sub` : `sub_q`.
  - cin = first ? (`in_cin` | `in_sub`) : `carry_q`.
  - first = (`cnt`==0) || `in_first`.
- On accept:
  - `out_sum` ← sum; `carry_q` ← cout; `out_valid` ← 1.
  - `out_last` ← (effective index == WORDS-1).
  - `out_cout` ← cout if last, else 0.
  - `out_ovf` ← (a[15]==b'[15]) && (sum[15]!=a[15]) if last, else 0, where b' is the post-inversion b.
  - `cnt` ← 0 if last, else effective index + 1.
  - If first, `sub_q` ← `in_sub`.
- Effective index is 0 when first, otherwise `cnt`.
- `in_first` while `cnt`≠0 aborts the partial operand:
  - The limb is treated as limb 0 of a new operand.
  - `err` ← 1.
  - Limbs already emitted are not retracted, and no `out_last` is produced for the aborted operand.
- `in_first`=0 while `cnt`==0 is legal; the limb is treated as first.
- Subtract semantics:
  - `out_cout`=1 means no borrow.
  - `in_cin` is ORed with `in_sub` on the first limb, so subtract always adds +1 to complete the two's complement.
- Output handshake:
  - `in_ready` = !`out_valid` || `out_ready` (combinational).
  - If the output is taken and no new limb is accepted in the same cycle, `out_valid` ← 0.
  - Output registers hold their values while `out_valid` && !`out_ready`.
- Reset, asynchronous, at any time including mid-operand:
  - `out_valid`, `out_sum`, `out_last`, `out_cout`, `out_ovf`, `err`, `cnt`, `carry_q`, `sub_q` all ← 0.
  - The partial operand is discarded, and the next accepted limb is limb 0.

## Timing
- Latency: accept at edge N → `out_valid`=1 with the result from edge N.
- Throughput: one limb per cycle when `out_ready` is held at 1.
- A full operand takes WORDS accepted cycles; there are no bubbles between operands.
- `in_ready`=1 during and immediately after reset, since `out_valid`=0.
- Simultaneous output take and new accept in the same cycle: the register is reloaded and `out_valid` stays 1.
- The adder path is combinational from inputs to the output registers; the critical path is the four chained 4-bit carry-lookahead blocks of `cla_16bit`.

## Structure
- Package `mp_add_pkg`:
  - `LIMB_W` = 16.
  - Limb typedef, `logic [LIMB_W-1:0]`.
  - Helper function for signed overflow from (a_msb, b_msb, s_msb).
- One sub-module: the existing `cla_16bit`, instantiated once. No other hierarchy.
- `cnt` width is $clog2(WORDS).

## Test plan
All scenarios use WORDS=4 with limbs listed LSB first.
1. Add without overflow:
   - Stimulus: 0x00000000_FFFFFFFF + 0x1, cin=0.
   - Required: `out_sum` 0x0000, 0x0000, 0x0001, 0x0000; `out_last` on the 4th limb only; `out_cout`=0; `out_ovf`=0.
2. Add with full wrap:
   - Stimulus: 0xFFFFFFFF_FFFFFFFF + 0x1.
   - Required: all limbs 0x0000; `out_cout`=1; `out_ovf`=0.
3. Subtract with borrow:
   - Stimulus: `in_sub`=1, 5 − 7.
   - Required: 0xFFFE, 0xFFFF, 0xFFFF, 0xFFFF; `out_cout`=0 (borrow); `out_ovf`=0.
4. Signed overflow:
   - Stimulus: 0x7FFFFFFF_FFFFFFFF + 1.
   - Required: 0x0000, 0x0000, 0x0000, 0x8000; `out_ovf`=1; `out_cout`=0.
5. Backpressure:
   - Stimulus: `out_ready`=0 for 3 cycles mid-operand.
   - Required: `in_ready`=0; `out_sum` held stable; no limb lost or duplicated; results identical to scenario 1.
6. Abort and reset:
   - Stimulus: `in_first` asserted on the 3rd limb.
     - Required: `err`=1; the new operand completes correctly.
   - Stimulus: `rst` asserted after 2 limbs of an operand.
     - Required: all outputs 0 and `err`=0; the next operand's first limb is treated as limb 0.

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision adder slice.
//   LIMB_W     : width of one operand limb
//   limb_t     : one limb
//   signed_ovf : two's-complement overflow from the operand and result sign bits
package mp_add_pkg;

  localparam int LIMB_W = 16;

  typedef logic [LIMB_W-1:0] limb_t;

  // Overflow happens when both addends share a sign and the sum's sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_16bit.sv
// 16-bit adder built from four 4-bit carry-lookahead blocks whose group
// carries are chained block to block.
//   a, b : addends
//   cin  : carry into bit 0
//   sum  : a + b + cin, low 16 bits
//   cout : carry out of bit 15
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  logic       carry;

  always_comb begin
    // NOTE: every variable written here gets a value before any branch or
    // loop, so no path can leave one unassigned and infer a latch.
    sum   = '0;
    g     = '0;
    p     = '0;
    c     = '0;
    carry = cin;
    for (int k = 0; k < 4; k++) begin
      g    = a[4*k +: 4] & b[4*k +: 4];
      p    = a[4*k +: 4] ^ b[4*k +: 4];
      c[0] = carry;
      // Lookahead within the block: each carry is a flat sum of products of
      // the block's generate/propagate terms and its carry-in.
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
      sum[4*k +: 4] = p ^ c[3:0];
      carry = c[4];
    end
    cout = carry;
  end

endmodule

// File: rtl/mp_add_seq.sv
// Sequential multi-precision adder/subtractor. Operands arrive as 16-bit
// limbs, least-significant first; one cla_16bit does every limb and the
// carry between limbs is kept in a register.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : limb presented;  in_ready : limb accepted when both high
//   in_a, in_b : operand limbs;   in_first : limb 0 of a new operand
//   in_cin     : carry-in (first limb only)
//   in_sub     : A-B, sampled on the first limb, held for the operand
//   out_valid  : result limb held; out_ready : consumer takes it
//   out_sum    : result limb;     out_last : most-significant limb
//   out_cout   : final carry (1 = no borrow when subtracting), last limb only
//   out_ovf    : signed overflow of the full-width result, last limb only
//   err        : sticky, set when in_first aborts a partial operand
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  limb_t in_a,
  input  limb_t in_b,
  input  logic  in_first,
  input  logic  in_cin,
  input  logic  in_sub,
  output logic  out_valid,
  input  logic  out_ready,
  output limb_t out_sum,
  output logic  out_last,
  output logic  out_cout,
  output logic  out_ovf,
  output logic  err
);

  localparam int                 CNT_W    = $clog2(WORDS);
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(WORDS - 1);

  logic [CNT_W-1:0] cnt;
  logic             carry_q;
  logic             sub_q;

  logic             accept;
  logic             first;
  logic             sub_eff;
  logic [CNT_W-1:0] eff_idx;
  logic             is_last;
  limb_t            b_eff;
  logic             cin_eff;
  limb_t            sum;
  logic             cout;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A limb is limb 0 either because the counter is idle or because the source
  // says so; the latter mid-operand discards the partial operand.
  assign first   = (cnt == '0) || in_first;
  assign eff_idx = first ? '0 : cnt;
  assign is_last = (eff_idx == LAST_IDX);

  // Subtraction is A + ~B + 1: invert B on every limb and force the +1 in as
  // the carry of limb 0.
  assign sub_eff = first ? in_sub : sub_q;
  assign b_eff   = in_b ^ {LIMB_W{sub_eff}};
  assign cin_eff = first ? (in_cin | in_sub) : carry_q;

  cla_16bit u_cla (
    .a    (in_a),
    .b    (b_eff),
    .cin  (cin_eff),
    .sum  (sum),
    .cout (cout)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      err       <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= sum;
      out_last  <= is_last;
      out_cout  <= is_last && cout;
      out_ovf   <= is_last && signed_ovf(in_a[LIMB_W-1], b_eff[LIMB_W-1], sum[LIMB_W-1]);
      carry_q   <= cout;
      cnt       <= is_last ? '0 : eff_idx + CNT_W'(1);
      if (first) begin
        sub_q <= in_sub;
      end
      if (in_first && (cnt != '0)) begin
        err <= 1'b1;
      end
    end else if (out_ready) begin
      // Output taken with nothing new behind it.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (WORDS = 4). Expected results come from
// full-width 64-bit arithmetic on whole operands, split into limbs afterwards.
module tb_mp_add_seq;

  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_first;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_last;
  logic        out_cout;
  logic        out_ovf;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Whole-operand reference: unsigned result and carry, plus signed range check.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic sub, output logic [63:0] r, output logic co,
                       output logic ov);
    logic [64:0]        wide;
    logic signed [65:0] sa, sb, sr;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    if (!sub) begin
      wide = {1'b0, a} + {1'b0, b} + 65'(cin);
      sr   = sa + sb + $signed({65'd0, cin});
      co   = wide[64];
    end else begin
      wide = {1'b0, a} - {1'b0, b};
      sr   = sa - sb;
      co   = (a >= b);
    end
    r  = wide[63:0];
    ov = (sr[65:63] != {3{sr[63]}});
  endtask

  // Sends limbs 0..n-1 back to back with out_ready high and checks each result.
  task automatic send_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic sub, input int n, input logic mark_first,
                         input string tag);
    logic [63:0] r;
    logic        co, ov;
    model(a, b, cin, sub, r, co, ov);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a[16*i +: 16];
      in_b     = b[16*i +: 16];
      in_first = mark_first && (i == 0);
      in_cin   = (i == 0) ? cin : 1'($urandom);
      in_sub   = (i == 0) ? sub : 1'($urandom);
      chk($sformatf("%s in_ready[%0d]", tag, i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("%s valid[%0d]", tag, i), 32'(out_valid), 32'd1);
      chk($sformatf("%s sum[%0d]", tag, i), 32'(out_sum), 32'(r[16*i +: 16]));
      chk($sformatf("%s last[%0d]", tag, i), 32'(out_last), 32'(i == WORDS - 1));
      chk($sformatf("%s cout[%0d]", tag, i), 32'(out_cout), 32'((i == WORDS - 1) && co));
      chk($sformatf("%s ovf[%0d]", tag, i), 32'(out_ovf), 32'((i == WORDS - 1) && ov));
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_sum"}, 32'(out_sum), 32'd0);
    chk({tag, " out_last"}, 32'(out_last), 32'd0);
    chk({tag, " out_cout"}, 32'(out_cout), 32'd0);
    chk({tag, " out_ovf"}, 32'(out_ovf), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [63:0] a, b, r;
    logic        co, ov, sub, cin;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_first  = 1'b0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed scenarios from the plan.
    send_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4, 1'b1, "add_nowrap");
    send_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4, 1'b1, "add_wrap");
    send_op(64'd5, 64'd7, 1'b0, 1'b1, 4, 1'b1, "sub_borrow");
    send_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4, 1'b1, "ovf");
    go_idle();
    @(posedge clk);
    #1;
    chk("drain out_valid", 32'(out_valid), 32'd0);

    // Backpressure: stall the consumer while limb 2 waits at the input.
    a = 64'h0000_0000_FFFF_FFFF;
    b = 64'h1;
    model(a, b, 1'b0, 1'b0, r, co, ov);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a[16*i +: 16];
      in_b     = b[16*i +: 16];
      in_first = (i == 0);
      in_cin   = 1'b0;
      in_sub   = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("bp sum[%0d]", i), 32'(out_sum), 32'(r[16*i +: 16]));
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_a      = a[32 +: 16];
    in_b      = b[32 +: 16];
    in_first  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp in_ready stall%0d", k), 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("bp hold valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp hold sum%0d", k), 32'(out_sum), 32'(r[16 +: 16]));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp sum[2]", 32'(out_sum), 32'(r[32 +: 16]));
    chk("bp last[2]", 32'(out_last), 32'd0);
    @(negedge clk);
    in_a = a[48 +: 16];
    in_b = b[48 +: 16];
    @(posedge clk);
    #1;
    chk("bp sum[3]", 32'(out_sum), 32'(r[48 +: 16]));
    chk("bp last[3]", 32'(out_last), 32'd1);
    chk("bp cout", 32'(out_cout), 32'(co));
    chk("bp ovf", 32'(out_ovf), 32'(ov));
    go_idle();

    // Abort: a new operand starts on what would have been limb 2.
    send_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 2, 1'b1, "pre_abort");
    #1;
    chk("err before abort", 32'(err), 32'd0);
    send_op(64'h8000_0000_0000_0001, 64'h0000_0000_0000_0003, 1'b0, 1'b1, 4, 1'b1, "abort_new");
    chk("err after abort", 32'(err), 32'd1);

    // Reset mid-operand, then an operand with in_first never asserted.
    send_op(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 2, 1'b1, "pre_rst");
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    send_op(64'h0001_0002_0003_FFFF, 64'h0004_0005_0006_0001, 1'b0, 1'b0, 4, 1'b0, "post_rst");

    // Random operands, back to back, first flag mixed.
    for (int t = 0; t < 24; t++) begin
      a   = {32'($urandom), 32'($urandom)};
      b   = {32'($urandom), 32'($urandom)};
      if (t % 6 == 0) a[63:48] = 16'h7FFF;
      if (t % 6 == 1) b = ~a;
      sub = 1'($urandom);
      cin = 1'($urandom);
      send_op(a, b, cin, sub, 4, 1'($urandom), $sformatf("rnd%0d", t));
    end
    go_idle();
    @(posedge clk);
    #1;
    chk("final out_valid", 32'(out_valid), 32'd0);
    chk("final err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
